// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - shared types and constants for the DAC frame sequencer
package dac_seq_pkg;

  localparam int N_CH     = 8;
  localparam int DATA_W   = 16;
  localparam int PERIOD_W = 32;
  localparam int FIFO_AW  = 2;
  localparam int FRAME_W  = N_CH * DATA_W + PERIOD_W + 1;

  localparam logic [DATA_W-1:0] MIDSCALE = 16'h8000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    READY,
    RUN,
    SAFE,
    STOP
  } state_t;

  typedef struct packed {
    logic [N_CH*DATA_W-1:0] data;
    logic [PERIOD_W-1:0]    period;
    logic                   last;
  } frame_t;

  // A frame can never be shorter than the time needed to write every channel.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] p);
    return (p < PERIOD_W'(N_CH)) ? PERIOD_W'(N_CH) : p;
  endfunction

endpackage

// File: rtl/dac_frame_fifo.sv
// rtl/dac_frame_fifo.sv - register FIFO of DAC frames with first-word-fall-through head
module dac_frame_fifo
  import dac_seq_pkg::*;
#(
  parameter int AW = FIFO_AW,
  parameter int W  = FRAME_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Frame storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; flush discards everything queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dac_frame_sequencer.sv
// rtl/dac_frame_sequencer.sv - paces buffered 8-channel frames onto per-channel DAC strobes
module dac_frame_sequencer
  import dac_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   halt,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [PERIOD_W-1:0]    in_period,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] value_out_concat,
  output logic [N_CH-1:0]        value_ready_concat,
  output logic                   dac_done,
  output logic                   busy,
  output logic                   err_underflow
);

  state_t                 state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [PERIOD_W-1:0]    cnt_q, cnt_d;
  logic [N_CH*DATA_W-1:0] cur_data_q;
  logic                   cur_last_q;
  logic                   to_idle_q, to_idle_d;
  logic [N_CH*DATA_W-1:0] value_q;
  logic [N_CH-1:0]        strobe_q;
  logic                   done_q;
  logic                   err_q;

  frame_t                 head;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, flush;
  logic                   wr_en, enter_safe, set_err, load_cur;
  logic [2:0]             wr_ch;
  logic [DATA_W-1:0]      wr_val;
  logic                   run_wr, expire;

  assign in_ready = ((state_q == READY) || (state_q == RUN)) && !fifo_full;
  assign push     = in_valid && in_ready;
  assign run_wr   = (state_q == RUN) && (idx_q < 4'(N_CH));
  assign expire   = (state_q == RUN) && !run_wr && (cnt_q == '0);

  assign value_out_concat   = value_q;
  assign value_ready_concat = strobe_q;
  assign dac_done           = done_q;
  assign busy               = (state_q == RUN);
  assign err_underflow      = err_q;

  dac_frame_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i ({in_data, in_period, in_last}),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection; halt outranks enable loss, underflow and expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable) state_d = INIT;
      INIT:  if (halt) state_d = SAFE;
             else if (idx_q == 4'd7) state_d = READY;
      READY: if (halt || !enable) state_d = SAFE;
             else if (!fifo_empty) state_d = RUN;
      RUN:   if (halt || !enable) state_d = SAFE;
             else if (expire) begin
               if (cur_last_q)      state_d = READY;
               else if (fifo_empty) state_d = SAFE;
             end
      SAFE:  if (idx_q == 4'd7) state_d = (to_idle_q && !halt) ? IDLE : STOP;
      STOP:  state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // Per-state actions: which channel is written with what, FIFO pops and counter loads.
  always_comb begin
    wr_en      = 1'b0;
    wr_ch      = idx_q[2:0];
    wr_val     = MIDSCALE;
    pop        = 1'b0;
    flush      = 1'b0;
    load_cur   = 1'b0;
    set_err    = 1'b0;
    enter_safe = 1'b0;
    idx_d      = idx_q;
    to_idle_d  = to_idle_q;
    cnt_d      = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        idx_d     = '0;
        to_idle_d = 1'b0;
      end
      INIT: begin
        if (halt) begin
          enter_safe = 1'b1;
          to_idle_d  = 1'b0;
        end else begin
          wr_en = 1'b1;
          idx_d = idx_q + 4'd1;
        end
      end
      READY, RUN: begin
        if (halt) begin
          enter_safe = 1'b1;
          to_idle_d  = 1'b0;
        end else if (!enable) begin
          enter_safe = 1'b1;
          flush      = 1'b1;
          to_idle_d  = 1'b1;
        end else if (run_wr) begin
          wr_en  = 1'b1;
          wr_val = cur_data_q[{idx_q[2:0], 4'b0000} +: DATA_W];
          idx_d  = idx_q + 4'd1;
        end else if ((state_q == READY) || (expire && !cur_last_q)) begin
          if (!fifo_empty) begin
            // Channel 0 of the next frame goes out on the edge that pops it.
            pop      = 1'b1;
            load_cur = 1'b1;
            wr_en    = 1'b1;
            wr_ch    = 3'd0;
            wr_val   = head.data[DATA_W-1:0];
            idx_d    = 4'd1;
            cnt_d    = eff_period(head.period) - 1'b1;
          end else if (state_q == RUN) begin
            enter_safe = 1'b1;
            set_err    = 1'b1;
          end
        end
      end
      SAFE: begin
        wr_en     = 1'b1;
        idx_d     = idx_q + 4'd1;
        to_idle_d = to_idle_q && !halt;
      end
      default: ;
    endcase
    // Safe shutdown starts immediately with the channel 0 midscale write.
    if (enter_safe) begin
      wr_en  = 1'b1;
      wr_ch  = 3'd0;
      wr_val = MIDSCALE;
      idx_d  = 4'd1;
    end
  end

  // Datapath registers: channel index, period counter, current frame and DAC outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      cnt_q      <= '0;
      cur_data_q <= '0;
      cur_last_q <= 1'b0;
      to_idle_q  <= 1'b0;
      value_q    <= {N_CH{MIDSCALE}};
      strobe_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      to_idle_q <= to_idle_d;
      if (load_cur) begin
        cur_data_q <= head.data;
        cur_last_q <= head.last;
      end
      if (wr_en) value_q[{wr_ch, 4'b0000} +: DATA_W] <= wr_val;
      strobe_q <= wr_en ? ({{(N_CH-1){1'b0}}, 1'b1} << wr_ch) : '0;
      done_q   <= (state_q == READY) || (state_q == RUN);
      if (set_err) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// tb/tb_dac_frame_sequencer.sv - directed checks of the DAC frame sequencer
module tb_dac_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         halt = 1'b0;
  logic [127:0] in_data = '0;
  logic [31:0]  in_period = '0;
  logic         in_last = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] value_out_concat;
  logic [7:0]   value_ready_concat;
  logic         dac_done;
  logic         busy;
  logic         err_underflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  localparam logic [127:0] ALL_MID = {8{16'h8000}};

  typedef struct {
    int          cyc;
    int          ch;
    logic [15:0] val;
  } ev_t;
  ev_t log_q[$];

  typedef struct {
    logic [7:0] exp_strobe;
    logic       exp_done;
  } init_vec_t;
  init_vec_t init_tab[12];

  dac_frame_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .halt               (halt),
    .in_data            (in_data),
    .in_period          (in_period),
    .in_last            (in_last),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .value_out_concat   (value_out_concat),
    .value_ready_concat (value_ready_concat),
    .dac_done           (dac_done),
    .busy               (busy),
    .err_underflow      (err_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && (value_ready_concat != 8'h00)) begin
      checks++;
      if (!$onehot(value_ready_concat)) begin
        errors++;
        $display("FAIL strobe_onehot: got %0h required one bit", value_ready_concat);
      end
      for (int k = 0; k < 8; k++)
        if (value_ready_concat[k]) log_q.push_back('{cyc, k, value_out_concat[k*16 +: 16]});
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [15:0] gv(input int f, input int k);
    return 16'((f + 1) * 4096 + k * 16 + 10);
  endfunction

  function automatic logic [127:0] gen(input int f);
    logic [127:0] d;
    for (int k = 0; k < 8; k++) d[k*16 +: 16] = gv(f, k);
    return d;
  endfunction

  task automatic push_frame(input int f, input logic [31:0] p, input logic l);
    int n;
    n = 0;
    in_data = gen(f); in_period = p; in_last = l; in_valid = 1'b1;
    while (!in_ready && n < 200) begin step(); n++; end
    check("push_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    enable = 1'b0; halt = 1'b0; in_valid = 1'b0;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    step();
    log_q.delete();
  endtask

  task automatic do_init();
    enable = 1'b1;
    wait_cycles(12);
    check("init_done", dac_done, 1'b1);
    log_q.delete();
  endtask

  initial begin
    int t0;
    int acc;
    for (int i = 0; i < 12; i++) init_tab[i] = '{8'h00, 1'b0};
    init_tab[1] = '{8'h01, 1'b0};
    init_tab[2] = '{8'h02, 1'b0};
    init_tab[3] = '{8'h04, 1'b0};
    init_tab[4] = '{8'h08, 1'b0};
    init_tab[5] = '{8'h10, 1'b0};
    init_tab[6] = '{8'h20, 1'b0};
    init_tab[7] = '{8'h40, 1'b0};
    init_tab[8] = '{8'h80, 1'b0};
    init_tab[9] = '{8'h00, 1'b1};
    init_tab[10] = '{8'h00, 1'b1};
    init_tab[11] = '{8'h00, 1'b1};

    // Reset state
    wait_cycles(2);
    check("rst_values", value_out_concat, ALL_MID);
    check("rst_strobe", value_ready_concat, 8'h00);
    check("rst_done", dac_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_underflow, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    wait_cycles(2);
    check("idle_in_ready", in_ready, 1'b0);

    // Initialisation sequence, one table row per cycle after enable rises
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("init_strobe[%0d]", i + 1), value_ready_concat, init_tab[i].exp_strobe);
      check($sformatf("init_done[%0d]", i + 1), dac_done, init_tab[i].exp_done);
    end
    check("init_values", value_out_concat, ALL_MID);
    check("ready_in_ready", in_ready, 1'b1);
    check("ready_busy", busy, 1'b0);
    log_q.delete();

    // Three frames at period 100, last one ends the sequence
    push_frame(0, 32'd100, 1'b0);
    push_frame(1, 32'd100, 1'b0);
    push_frame(2, 32'd100, 1'b1);
    step();
    check("play_busy", busy, 1'b1);
    wait_cycles(330);
    check("play_count", log_q.size(), 24);
    if (log_q.size() > 0) t0 = log_q[0].cyc;
    for (int i = 0; i < log_q.size() && i < 24; i++) begin
      check($sformatf("play_cyc[%0d]", i), log_q[i].cyc, t0 + 100 * (i / 8) + (i % 8));
      check($sformatf("play_ch[%0d]", i), log_q[i].ch, i % 8);
      check($sformatf("play_val[%0d]", i), log_q[i].val, gv(i / 8, i % 8));
    end
    check("play_busy_end", busy, 1'b0);
    check("play_in_ready_end", in_ready, 1'b1);
    check("play_done_end", dac_done, 1'b1);
    log_q.delete();

    // Short period clamps to back-to-back frames
    push_frame(3, 32'd3, 1'b0);
    push_frame(4, 32'd8, 1'b1);
    wait_cycles(30);
    check("short_count", log_q.size(), 16);
    if (log_q.size() >= 16) begin
      check("short_gap", log_q[8].cyc - log_q[0].cyc, 8);
      check("short_gap_contig", log_q[8].cyc - log_q[7].cyc, 1);
      check("short_b_ch0", log_q[8].val, gv(4, 0));
    end
    check("short_busy_end", busy, 1'b0);
    check("short_err", err_underflow, 1'b0);

    // Underflow: two frames without in_last and nothing after them
    do_reset();
    do_init();
    push_frame(1, 32'd20, 1'b0);
    push_frame(2, 32'd20, 1'b0);
    wait_cycles(60);
    check("uf_count", log_q.size(), 24);
    if (log_q.size() >= 24) begin
      t0 = log_q[0].cyc;
      check("uf_second_ch0", log_q[8].cyc, t0 + 20);
      for (int i = 16; i < 24; i++) begin
        check($sformatf("uf_safe_cyc[%0d]", i), log_q[i].cyc, t0 + 40 + (i - 16));
        check($sformatf("uf_safe_val[%0d]", i), log_q[i].val, 16'h8000);
      end
    end
    check("uf_err", err_underflow, 1'b1);
    check("uf_done", dac_done, 1'b0);
    check("uf_in_ready", in_ready, 1'b0);
    check("uf_values", value_out_concat, ALL_MID);

    // Halt while channel 3 is being written
    do_reset();
    do_init();
    push_frame(5, 32'd100, 1'b1);
    acc = 0;
    while (!value_ready_concat[3] && acc < 50) begin step(); acc++; end
    check("halt_saw_ch3", value_ready_concat, 8'h08);
    halt = 1'b1;
    wait_cycles(12);
    halt = 1'b0;
    wait_cycles(3);
    check("halt_count", log_q.size(), 12);
    if (log_q.size() >= 12) begin
      check("halt_ch3_val", log_q[3].val, gv(5, 3));
      for (int i = 4; i < 12; i++) begin
        check($sformatf("halt_safe_ch[%0d]", i), log_q[i].ch, i - 4);
        check($sformatf("halt_safe_val[%0d]", i), log_q[i].val, 16'h8000);
        check($sformatf("halt_safe_cyc[%0d]", i), log_q[i].cyc, log_q[3].cyc + 1 + (i - 4));
      end
    end
    check("halt_in_ready", in_ready, 1'b0);
    check("halt_done", dac_done, 1'b0);
    check("halt_err", err_underflow, 1'b0);

    // FIFO fills while a long frame plays, then asynchronous reset mid-frame
    do_reset();
    do_init();
    push_frame(6, 32'd1000, 1'b1);
    wait_cycles(3);
    acc = 0;
    in_data = gen(0); in_period = 32'd50; in_last = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (in_ready) begin
        acc++;
        step();
        in_data = gen(acc % 5);
        if (acc >= 5) in_valid = 1'b0;
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    check("full_accepted", acc, 4);
    check("full_in_ready", in_ready, 1'b0);
    check("run_busy", busy, 1'b1);
    check("run_slice0", value_out_concat[15:0], gv(6, 0));
    #3;
    rst = 1'b1;
    #1;
    check("async_values", value_out_concat, ALL_MID);
    check("async_strobe", value_ready_concat, 8'h00);
    check("async_busy", busy, 1'b0);
    check("async_done", dac_done, 1'b0);
    check("async_in_ready", in_ready, 1'b0);
    check("async_err", err_underflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
